xorexpand_lfsr_burst: RTL and testbench

//  Sequential successor to the combinational pairwise-XOR expander. Holds an internal

---
 rtl/xorexpand_lfsr_burst.sv | 139 +++++++++++++
 tb/tb_xorexpand_lfsr_burst.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xorexpand_lfsr_burst.sv
// Burst generator: Fibonacci LFSR whose pairwise-XOR expansion is thresholded in 4-bit
// windows into segment-enable words, streamed over valid/ready with a start/done protocol.
module xorexpand_lfsr_burst #(
  parameter int                 RNDSIZE      = 16,
  parameter int                 NB_OUT       = 16,
  parameter logic [RNDSIZE-1:0] TAPS         = 16'hB400,
  parameter logic [RNDSIZE-1:0] DEFAULT_SEED = 16'h0001,
  parameter int                 WARMUP       = 4,
  parameter int                 LEN_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_load,
  input  logic [RNDSIZE-1:0] seed,
  input  logic [1:0]         probability,
  input  logic               start,
  input  logic [LEN_W-1:0]   nb_words,
  output logic [NB_OUT-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  // Handshake: a word transfers on every rising edge where out_valid && out_ready;
  // once raised, out_valid and out_data stay put until that transfer happens.

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_DONE} state_t;

  localparam int NX   = NB_OUT * 4;
  localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WC_W-1:0] WC_INIT = WC_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  state_t             state;
  logic [RNDSIZE-1:0] r;
  logic [RNDSIZE-1:0] r_next;
  logic [RNDSIZE-1:0] seed_eff;
  logic [1:0]         prob_q;
  logic [LEN_W-1:0]   remaining;
  logic [WC_W-1:0]    wcnt;
  logic [NX-1:0]      x;
  logic [3:0]         thr;
  logic [NB_OUT-1:0]  seg;

  assign r_next    = {r[RNDSIZE-2:0], ^(r & TAPS)};
  assign seed_eff  = (seed == '0) ? {{(RNDSIZE-1){1'b0}}, 1'b1} : seed;
  assign dbg_state = state;

  // Only the expansion bits that feed a segment window are built.
  always_comb begin
    x = '0;
    for (int i = 0; i < RNDSIZE; i++) begin
      for (int j = i + 1; j < RNDSIZE; j++) begin
        int k;
        k = i * RNDSIZE - i * (i + 1) / 2 + j - i - 1;
        if (k < NX) x[k] = r[i] ^ r[j];
      end
    end
  end

  always_comb begin
    case (prob_q)
      2'b00:   thr = 4'd8;
      2'b01:   thr = 4'd10;
      2'b10:   thr = 4'd12;
      default: thr = 4'd15;
    endcase
  end

  always_comb begin
    seg = '0;
    for (int s = 0; s < NB_OUT; s++) seg[s] = (x[4*s +: 4] < thr);
  end

  assign out_data = out_valid ? seg : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      r         <= DEFAULT_SEED;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      prob_q    <= 2'b00;
      remaining <= '0;
      wcnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (seed_load) r <= seed_eff;
          if (start) begin
            prob_q    <= probability;
            remaining <= nb_words;
            busy      <= 1'b1;
            if (nb_words == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (WARMUP == 0) begin
              state     <= S_RUN;
              out_valid <= 1'b1;
            end else begin
              state <= S_WARMUP;
              wcnt  <= WC_INIT;
            end
          end
        end
        S_WARMUP: begin
          r <= r_next;
          if (wcnt == '0) begin
            state     <= S_RUN;
            out_valid <= 1'b1;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        S_RUN: begin
          if (out_ready) begin
            r <= r_next;
            if (remaining == LEN_W'(1)) begin
              state     <= S_DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xorexpand_lfsr_burst.sv
// Bench for xorexpand_lfsr_burst: two instances (no warm-up and 4-cycle warm-up) sharing
// stimulus, with a per-instance expected-word queue filled at start and drained on accept.
module tb_xorexpand_lfsr_burst;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0;
  logic [1:0]  probability = 2'b00;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [7:0]  nb_words = 8'd0;
  logic        out_ready = 1'b1;

  logic [15:0] od0, od1;
  logic        ov0, ov1, by0, by1, dn0, dn1;
  logic [1:0]  st0, st1;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] mr[2];
  int          acc_cnt[2];
  int          vcnt[2];
  int          done_cnt[2];
  bit          stat_on = 1'b0;
  int          ones = 0;

  always #5 clk = ~clk;

  xorexpand_lfsr_burst #(.WARMUP(0)) u0 (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .probability(probability),
    .start(start0), .nb_words(nb_words), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .busy(by0), .done(dn0), .dbg_state(st0));

  xorexpand_lfsr_burst #(.WARMUP(4)) u1 (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .probability(probability),
    .start(start1), .nb_words(nb_words), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .busy(by1), .done(dn1), .dbg_state(st1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  // Reference expansion: walk pairs (i<j) in order, numbering them consecutively.
  function automatic logic [15:0] model_word(input logic [15:0] v, input logic [1:0] p);
    logic [127:0] xb;
    logic [15:0]  w;
    int           k;
    int           t;
    xb = '0;
    k  = 0;
    for (int i = 0; i < 16; i++)
      for (int j = i + 1; j < 16; j++) begin
        xb[k] = v[i] ^ v[j];
        k++;
      end
    t = (p == 2'd0) ? 8 : (p == 2'd1) ? 10 : (p == 2'd2) ? 12 : 15;
    for (int s = 0; s < 16; s++) w[s] = (int'(xb[4*s +: 4]) < t);
    return w;
  endfunction

  task automatic mon(input int inst, input logic v, input logic [15:0] d, input logic dn);
    logic [15:0] e;
    if (v && out_ready) begin
      acc_cnt[inst]++;
      if ((inst == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        check($sformatf("extra_word%0d", inst), 32'd1, 32'd0);
      end else begin
        e = (inst == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("word%0d", inst), {16'h0, d}, {16'h0, e});
      end
      if (stat_on && inst == 0) ones += $countones(d);
    end
    if (!v) check($sformatf("idle_zero%0d", inst), {16'h0, d}, 32'h0);
    if (v) vcnt[inst]++;
    if (dn) done_cnt[inst]++;
  endtask

  always @(negedge clk) begin
    mon(0, ov0, od0, dn0);
    mon(1, ov1, od1, dn1);
  end

  // Both instances must be idle whenever ld=1, since seed_load is shared.
  task automatic do_start(input int inst, input logic [7:0] n, input logic [1:0] p,
                          input bit ld, input logic [15:0] sd);
    logic [15:0] v;
    @(posedge clk); #1;
    seed_load = ld; seed = sd; probability = p; nb_words = n;
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    if (ld) begin
      mr[0] = (sd == 16'h0) ? 16'h0001 : sd;
      mr[1] = mr[0];
    end
    v = mr[inst];
    if (n != 0 && inst == 1) repeat (4) v = lfsr_step(v);
    for (int i = 0; i < int'(n); i++) begin
      if (inst == 0) exp_q0.push_back(model_word(v, p));
      else           exp_q1.push_back(model_word(v, p));
      v = lfsr_step(v);
    end
    mr[inst] = v;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; seed_load = 1'b0;
    seed = 16'($urandom); probability = 2'($urandom); nb_words = 8'($urandom);
  endtask

  task automatic wait_valid(input int inst, input int budget, output int lat);
    lat = 0;
    while (lat < budget) begin
      @(negedge clk);
      lat++;
      if ((inst == 0) ? ov0 : ov1) return;
    end
    check($sformatf("valid_timeout%0d", inst), 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int inst, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((inst == 0) ? dn0 : dn1) return;
    end
    check($sformatf("done_timeout%0d", inst), 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int a0, d0, v0;
    int frac, diff;
    int tgt[4];
    logic [15:0] sd;
    tgt[0] = 5000; tgt[1] = 6250; tgt[2] = 7500; tgt[3] = 9375;
    mr[0] = 16'h0001; mr[1] = 16'h0001;
    for (int i = 0; i < 2; i++) begin acc_cnt[i] = 0; vcnt[i] = 0; done_cnt[i] = 0; end

    // 1: reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'h0, ov0 | ov1}, 32'd0);
    check("rst_data", {od1, od0}, 32'h0);
    check("rst_busy", {31'h0, by0 | by1}, 32'd0);
    check("rst_done", {31'h0, dn0 | dn1}, 32'd0);
    check("rst_state", {28'h0, st1, st0}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // 1b: reset seed drives the first word without any seed load
    do_start(0, 8'd1, 2'b11, 1'b0, 16'h0);
    wait_valid(0, 10, lat);
    check("rst_seed_word", {16'h0, od0}, 32'h0000FFF8);
    wait_done(0, 20);

    // 2: seed 1, no warm-up, prob 11
    do_start(0, 8'd1, 2'b11, 1'b1, 16'h0001);
    wait_valid(0, 10, lat);
    check("lat_w0", lat, 1);
    check("seed1_word", {16'h0, od0}, 32'h0000FFF8);
    @(negedge clk);
    check("done_pulse", {31'h0, dn0}, 32'd1);
    check("busy_in_done", {31'h0, by0}, 32'd1);
    @(negedge clk);
    check("done_fall", {31'h0, dn0}, 32'd0);
    check("busy_fall", {31'h0, by0}, 32'd0);

    // 3: zero seed behaves as seed 1
    do_start(0, 8'd1, 2'b11, 1'b1, 16'h0000);
    wait_valid(0, 10, lat);
    check("seed0_word", {16'h0, od0}, 32'h0000FFF8);
    wait_done(0, 20);

    // 4: warm-up latency, stall on word 2, mid-burst seed_load ignored by the busy instance
    a0 = acc_cnt[1]; d0 = done_cnt[1];
    do_start(1, 8'd3, 2'b10, 1'b1, 16'($urandom_range(1, 65535)));
    wait_valid(1, 20, lat);
    check("lat_w4", lat, 5);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'h0, ov1}, 32'd1);
      check("stall_data", {16'h0, od1}, {16'h0, exp_q1[0]});
      if (i == 0) begin seed_load = 1'b1; seed = 16'h1234; mr[0] = 16'h1234; end
      if (i == 1) seed_load = 1'b0;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done(1, 50);
    repeat (4) @(negedge clk);
    check("accepts3", acc_cnt[1] - a0, 3);
    check("single_done", done_cnt[1] - d0, 1);
    check("q1_empty", exp_q1.size(), 0);

    // 5: zero-length burst, and start while busy
    v0 = vcnt[0];
    do_start(0, 8'd0, 2'b00, 1'b0, 16'h0);
    @(negedge clk);
    check("zero_len_done", {31'h0, dn0}, 32'd1);
    @(negedge clk);
    check("zero_len_done_fall", {31'h0, dn0}, 32'd0);
    check("zero_len_no_valid", vcnt[0] - v0, 0);
    a0 = acc_cnt[1];
    out_ready = 1'b0;
    do_start(1, 8'd2, 2'b01, 1'b0, 16'h0);
    start1 = 1'b1; nb_words = 8'd5; probability = 2'b11;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (6) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(1, 50);
    repeat (3) @(negedge clk);
    check("busy_start_ignored", acc_cnt[1] - a0, 2);
    check("q1_empty2", exp_q1.size(), 0);

    // 6: reset mid-burst after 2 of 10 words
    a0 = acc_cnt[0]; d0 = done_cnt[0];
    do_start(0, 8'd10, 2'b01, 1'b0, 16'h0);
    wait_valid(0, 10, lat);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_accepts", acc_cnt[0] - a0, 2);
    check("mid_rst_valid", {31'h0, ov0}, 32'd0);
    check("mid_rst_data", {16'h0, od0}, 32'h0);
    check("mid_rst_busy", {31'h0, by0}, 32'd0);
    check("mid_rst_state", {30'h0, st0}, 32'h0);
    exp_q0.delete();
    mr[0] = 16'h0001; mr[1] = 16'h0001;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_no_done", done_cnt[0] - d0, 0);
    do_start(0, 8'd1, 2'b11, 1'b0, 16'h0);
    wait_valid(0, 10, lat);
    check("post_rst_seed", {16'h0, od0}, 32'h0000FFF8);
    wait_done(0, 20);

    // 6b: ones fraction per probability code over 4096 words
    for (int p = 0; p < 4; p++) begin
      ones = 0;
      stat_on = 1'b1;
      sd = 16'($urandom_range(1, 65535));
      for (int b = 0; b < 17; b++) begin
        do_start(0, (b < 16) ? 8'd255 : 8'd16, 2'(p), (b == 0), sd);
        wait_done(0, 600);
      end
      @(negedge clk);
      stat_on = 1'b0;
      frac = ones * 10000 / (4096 * 16);
      diff = (frac > tgt[p]) ? frac - tgt[p] : tgt[p] - frac;
      $display("prob code %0d: ones fraction %0d/10000", p, frac);
      check($sformatf("prob_frac%0d", p), {31'h0, diff <= 300}, 32'd1);
    end
    check("q0_empty", exp_q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
